// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer with load validation, start/stop/clear control
// and a one-cycle alarm when the count reaches 00:00.
module countdown_timer (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] ld_minH,
    input  logic [3:0] ld_minL,
    input  logic [3:0] ld_secH,
    input  logic [3:0] ld_secL,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] minH,
    output logic [3:0] minL,
    output logic [3:0] secH,
    output logic [3:0] secL,
    output logic       running,
    output logic       done,
    output logic       alarm,
    output logic       load_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0] state, state_nxt;
    logic [3:0] min_h_nxt, min_l_nxt, sec_h_nxt, sec_l_nxt;
    logic       alarm_nxt, load_err_nxt;

    logic       ld_valid, is_zero, dec_zero;
    logic [3:0] dec_min_h, dec_min_l, dec_sec_h, dec_sec_l;

    assign ld_valid = (ld_minH <= 4'd5) && (ld_minL <= 4'd9) &&
                      (ld_secH <= 4'd5) && (ld_secL <= 4'd9);
    assign is_zero  = (minH == 4'd0) && (minL == 4'd0) &&
                      (secH == 4'd0) && (secL == 4'd0);

    // One-second decrement with borrow chain; only used in RUN, where the
    // value is never 00:00, so the minute borrow cannot underflow.
    always_comb begin
        dec_min_h = minH;
        dec_min_l = minL;
        dec_sec_h = secH;
        dec_sec_l = secL;
        if (secL != 4'd0) begin
            dec_sec_l = secL - 4'd1;
        end else if (secH != 4'd0) begin
            dec_sec_l = 4'd9;
            dec_sec_h = secH - 4'd1;
        end else begin
            dec_sec_l = 4'd9;
            dec_sec_h = 4'd5;
            if (minL != 4'd0) begin
                dec_min_l = minL - 4'd1;
            end else begin
                dec_min_l = 4'd9;
                dec_min_h = minH - 4'd1;
            end
        end
    end

    assign dec_zero = (dec_min_h == 4'd0) && (dec_min_l == 4'd0) &&
                      (dec_sec_h == 4'd0) && (dec_sec_l == 4'd0);

    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt    = state;
        min_h_nxt    = minH;
        min_l_nxt    = minL;
        sec_h_nxt    = secH;
        sec_l_nxt    = secL;
        alarm_nxt    = 1'b0;
        load_err_nxt = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            min_h_nxt = 4'd0;
            min_l_nxt = 4'd0;
            sec_h_nxt = 4'd0;
            sec_l_nxt = 4'd0;
        end else if (load) begin
            if (state != RUN) begin
                if (ld_valid) begin
                    state_nxt = IDLE;
                    min_h_nxt = ld_minH;
                    min_l_nxt = ld_minL;
                    sec_h_nxt = ld_secH;
                    sec_l_nxt = ld_secL;
                end else begin
                    load_err_nxt = 1'b1;
                end
            end
        end else if (stop) begin
            if (state == RUN) state_nxt = PAUSE;
        end else if (start) begin
            if ((state == IDLE || state == PAUSE) && !is_zero) state_nxt = RUN;
        end else if (tick && state == RUN) begin
            min_h_nxt = dec_min_h;
            min_l_nxt = dec_min_l;
            sec_h_nxt = dec_sec_h;
            sec_l_nxt = dec_sec_l;
            if (dec_zero) begin
                state_nxt = DONE;
                alarm_nxt = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            minH     <= 4'd0;
            minL     <= 4'd0;
            secH     <= 4'd0;
            secL     <= 4'd0;
            alarm    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            minH     <= min_h_nxt;
            minL     <= min_l_nxt;
            secH     <= sec_h_nxt;
            secL     <= sec_l_nxt;
            alarm    <= alarm_nxt;
            load_err <= load_err_nxt;
        end
    end

    assign running = (state == RUN);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer: directed scenarios with literal expectations
// plus randomized command streams checked against a seconds-based model.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic [3:0] ld_minH = '0, ld_minL = '0, ld_secH = '0, ld_secL = '0;
    logic [3:0] minH, minL, secH, secL;
    logic       running, done, alarm, load_err;

    int n_checks = 0;
    int n_pass   = 0;

    countdown_timer dut (
        .clk(clk), .rstn(rstn), .tick(tick), .load(load),
        .ld_minH(ld_minH), .ld_minL(ld_minL), .ld_secH(ld_secH), .ld_secL(ld_secL),
        .start(start), .stop(stop), .clear(clear),
        .minH(minH), .minL(minL), .secH(secH), .secL(secL),
        .running(running), .done(done), .alarm(alarm), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Reference model: remaining time held as a plain count of seconds.
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} m_state_t;
    m_state_t m_state = M_IDLE;
    int       m_secs  = 0;
    logic     m_alarm = 1'b0;
    logic     m_err   = 1'b0;

    function automatic logic preset_ok(input logic [15:0] v);
        return (v[15:12] <= 4'd5) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    function automatic int preset_secs(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] secs_bcd(input int s);
        int m = s / 60;
        int r = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    function automatic void model_reset();
        m_state = M_IDLE;
        m_secs  = 0;
        m_alarm = 1'b0;
        m_err   = 1'b0;
    endfunction

    function automatic void model_step(input logic c, input logic l, input logic [15:0] v,
                                       input logic sp, input logic st, input logic tk);
        m_alarm = 1'b0;
        m_err   = 1'b0;
        if (c) begin
            m_state = M_IDLE;
            m_secs  = 0;
        end else if (l) begin
            if (m_state != M_RUN) begin
                if (preset_ok(v)) begin
                    m_secs  = preset_secs(v);
                    m_state = M_IDLE;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (sp) begin
            if (m_state == M_RUN) m_state = M_PAUSE;
        end else if (st) begin
            if ((m_state == M_IDLE || m_state == M_PAUSE) && m_secs != 0) m_state = M_RUN;
        end else if (tk && m_state == M_RUN) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
                m_state = M_DONE;
                m_alarm = 1'b1;
            end
        end
    endfunction

    function automatic logic [19:0] model_obs();
        return {secs_bcd(m_secs), m_state == M_RUN, m_state == M_DONE, m_alarm, m_err};
    endfunction

    // Observed outputs packed as {MM:SS BCD, running, done, alarm, load_err}.
    function automatic logic [19:0] obs();
        return {minH, minL, secH, secL, running, done, alarm, load_err};
    endfunction

    task automatic cycle(input logic c, input logic l, input logic [15:0] v,
                         input logic sp, input logic st, input logic tk);
        clear = c; load = l; stop = sp; start = st; tick = tk;
        {ld_minH, ld_minL, ld_secH, ld_secL} = v;
        model_step(c, l, v, sp, st, tk);
        @(posedge clk);
        #1;
        clear = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0; tick = 1'b0;
    endtask

    task automatic do_clear();              cycle(1, 0, 16'h0, 0, 0, 0); endtask
    task automatic do_load(input logic [15:0] v); cycle(0, 1, v, 0, 0, 0); endtask
    task automatic do_start();              cycle(0, 0, 16'h0, 0, 1, 0); endtask
    task automatic do_tick();               cycle(0, 0, 16'h0, 0, 0, 1); endtask
    task automatic do_idle();               cycle(0, 0, 16'h0, 0, 0, 0); endtask

    task automatic test_reset();
        rstn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (obs() !== 20'h0) $display("FAIL reset_hold: got %h want %h", obs(), 20'h0);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        do_idle();
        n_checks++;
        if (obs() !== 20'h0) $display("FAIL reset_release: got %h want %h", obs(), 20'h0);
        else n_pass++;
    endtask

    task automatic test_countdown();
        do_load(16'h0100);
        do_start();
        do_tick();
        n_checks++;
        if (obs() !== {16'h0059, 4'b1000}) $display("FAIL first_tick: got %h want %h", obs(), {16'h0059, 4'b1000});
        else n_pass++;
        for (int i = 0; i < 58; i++) begin
            do_tick();
            n_checks++;
            if (alarm !== 1'b0 || running !== 1'b1)
                $display("FAIL early_alarm step %0d: alarm=%b running=%b want 0/1", i, alarm, running);
            else n_pass++;
        end
        n_checks++;
        if (obs() !== {16'h0001, 4'b1000}) $display("FAIL at_0001: got %h want %h", obs(), {16'h0001, 4'b1000});
        else n_pass++;
        do_tick();
        n_checks++;
        if (obs() !== {16'h0000, 4'b0110}) $display("FAIL reach_done: got %h want %h", obs(), {16'h0000, 4'b0110});
        else n_pass++;
        do_idle();
        n_checks++;
        if (obs() !== {16'h0000, 4'b0100}) $display("FAIL alarm_one_cycle: got %h want %h", obs(), {16'h0000, 4'b0100});
        else n_pass++;
    endtask

    task automatic test_borrow();
        do_clear();
        do_load(16'h1000);
        do_start();
        do_tick();
        n_checks++;
        if (obs() !== {16'h0959, 4'b1000}) $display("FAIL minute_borrow: got %h want %h", obs(), {16'h0959, 4'b1000});
        else n_pass++;
        do_clear();
        do_load(16'h0010);
        do_start();
        do_tick();
        n_checks++;
        if (obs() !== {16'h0009, 4'b1000}) $display("FAIL sech_borrow: got %h want %h", obs(), {16'h0009, 4'b1000});
        else n_pass++;
        do_tick();
        n_checks++;
        if (obs() !== {16'h0008, 4'b1000}) $display("FAIL after_borrow: got %h want %h", obs(), {16'h0008, 4'b1000});
        else n_pass++;
    endtask

    task automatic test_load_err();
        do_clear();
        do_load(16'h1234);
        do_load(16'h6000);
        n_checks++;
        if (obs() !== {16'h1234, 4'b0001}) $display("FAIL bad_minH: got %h want %h", obs(), {16'h1234, 4'b0001});
        else n_pass++;
        do_idle();
        n_checks++;
        if (obs() !== {16'h1234, 4'b0000}) $display("FAIL err_one_cycle: got %h want %h", obs(), {16'h1234, 4'b0000});
        else n_pass++;
        do_load(16'h000A);
        n_checks++;
        if (obs() !== {16'h1234, 4'b0001}) $display("FAIL bad_secL: got %h want %h", obs(), {16'h1234, 4'b0001});
        else n_pass++;
        do_load(16'h0000);
        do_start();
        n_checks++;
        if (obs() !== {16'h0000, 4'b0000}) $display("FAIL start_at_zero: got %h want %h", obs(), {16'h0000, 4'b0000});
        else n_pass++;
    endtask

    task automatic test_pause();
        do_load(16'h0005);
        do_start();
        do_tick();
        do_tick();
        n_checks++;
        if (obs() !== {16'h0003, 4'b1000}) $display("FAIL pause_pre: got %h want %h", obs(), {16'h0003, 4'b1000});
        else n_pass++;
        cycle(0, 0, 16'h0, 1, 0, 1);
        n_checks++;
        if (obs() !== {16'h0003, 4'b0000}) $display("FAIL stop_with_tick: got %h want %h", obs(), {16'h0003, 4'b0000});
        else n_pass++;
        repeat (3) do_tick();
        n_checks++;
        if (obs() !== {16'h0003, 4'b0000}) $display("FAIL paused_ticks: got %h want %h", obs(), {16'h0003, 4'b0000});
        else n_pass++;
        cycle(0, 0, 16'h0, 0, 1, 1);
        n_checks++;
        if (obs() !== {16'h0003, 4'b1000}) $display("FAIL start_with_tick: got %h want %h", obs(), {16'h0003, 4'b1000});
        else n_pass++;
        repeat (3) do_tick();
        n_checks++;
        if (obs() !== {16'h0000, 4'b0110}) $display("FAIL resume_done: got %h want %h", obs(), {16'h0000, 4'b0110});
        else n_pass++;
    endtask

    task automatic test_run_load_clear_done();
        do_clear();
        do_load(16'h0010);
        do_start();
        do_load(16'h3000);
        n_checks++;
        if (obs() !== {16'h0010, 4'b1000}) $display("FAIL load_in_run: got %h want %h", obs(), {16'h0010, 4'b1000});
        else n_pass++;
        cycle(1, 1, 16'h1111, 0, 0, 0);
        n_checks++;
        if (obs() !== {16'h0000, 4'b0000}) $display("FAIL clear_over_load: got %h want %h", obs(), {16'h0000, 4'b0000});
        else n_pass++;
        do_load(16'h0001);
        do_start();
        do_tick();
        do_tick();
        n_checks++;
        if (obs() !== {16'h0000, 4'b0100}) $display("FAIL tick_in_done: got %h want %h", obs(), {16'h0000, 4'b0100});
        else n_pass++;
        do_load(16'h0002);
        n_checks++;
        if (obs() !== {16'h0002, 4'b0000}) $display("FAIL load_from_done: got %h want %h", obs(), {16'h0002, 4'b0000});
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_clear();
        do_load(16'h1235);
        do_start();
        do_tick();
        n_checks++;
        if (obs() !== {16'h1234, 4'b1000}) $display("FAIL pre_reset: got %h want %h", obs(), {16'h1234, 4'b1000});
        else n_pass++;
        rstn = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs() !== 20'h0) $display("FAIL async_reset: got %h want %h", obs(), 20'h0);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        do_start();
        n_checks++;
        if (obs() !== 20'h0) $display("FAIL start_after_reset: got %h want %h", obs(), 20'h0);
        else n_pass++;
    endtask

    task automatic test_random();
        int r;
        logic c, l, sp, st, tk;
        logic [15:0] v;
        for (int i = 0; i < 1500; i++) begin
            r  = int'($urandom_range(0, 99));
            c  = (r < 2);
            l  = (r >= 2 && r < 8);
            sp = (r >= 8 && r < 12);
            st = (r >= 12 && r < 20);
            tk = l ? 1'b0 : ($urandom_range(0, 3) != 0);
            v[15:12] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 6)) : 4'd0;
            v[11:8]  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 11)) : 4'($urandom_range(0, 1));
            v[7:4]   = 4'($urandom_range(0, 6));
            v[3:0]   = 4'($urandom_range(0, 10));
            cycle(c, l, v, sp, st, tk);
            n_checks++;
            if (obs() !== model_obs())
                $display("FAIL random cycle %0d: got %h want %h", i, obs(), model_obs());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow();
        test_load_err();
        test_pause();
        test_run_load_clear_done();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
